btn_event_arbiter: RTL and testbench

- Collects single-cycle debounced posedge pulses from the 4 front-panel buttons (RESET, ADMIN, OK, BACKSPACE = indices 0..3).
- Arbitrates simultaneous and near-simultaneous presses round-robin, so no event is lost or merged.
- Delivers events one at a time through a small FIFO with a valid/ready handshake to the lock control FSM.
- Sits between the per-button debounce/edge stage and the password/admin state machine.

---
 rtl/btn_event_arbiter.sv | 141 ++++++++++++++
 tb/tb_btn_event_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter + event FIFO for the front-panel button pulses.
// Ports: CLK, RESET (sync, active low), BTN_POSEDGE, EVT_READY, CLR_OVF,
//        EVT_VALID, EVT_ID, PENDING, FIFO_CNT, OVERFLOW.
// Option: BTN_EVT_RESET_PRIORITY_EN makes button 0 a queue flush.
module btn_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int IDX_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_BTN-1:0] BTN_POSEDGE,
  input  logic             EVT_READY,
  input  logic             CLR_OVF,
  output logic             EVT_VALID,
  output logic [IDX_W-1:0] EVT_ID,
  output logic [N_BTN-1:0] PENDING,
  output logic [CNT_W-1:0] FIFO_CNT,
  output logic             OVERFLOW
);

  localparam int PTR_W = CNT_W - 1;

  logic [N_BTN-1:0] pend_q;
  logic [IDX_W-1:0] rr_last_q;
  logic [IDX_W-1:0] head_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic             ovf_q;
  logic [IDX_W-1:0] mem [FIFO_DEPTH];

  logic             flush;
  logic             pop;
  logic             push_ok;
  logic             gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic [N_BTN-1:0] gnt_oh;
  logic [N_BTN-1:0] drops;
  logic             push;
  logic [N_BTN-1:0] pend_nxt;
  logic             ovf_nxt;
  logic [CNT_W-1:0] cnt_rem;
  logic [CNT_W-1:0] cnt_nxt;
  logic [PTR_W-1:0] rd_nxt;
  logic [PTR_W-1:0] wr_nxt;
  logic [IDX_W-1:0] head_nxt;

`ifdef BTN_EVT_RESET_PRIORITY_EN
  assign flush = BTN_POSEDGE[0];
`else
  assign flush = 1'b0;
`endif

  assign pop     = (cnt_q != '0) && EVT_READY;
  assign push_ok = (cnt_q < CNT_W'(FIFO_DEPTH)) || pop;

  // Search starts just after the last winner, so every
  // requester is reached within N_BTN grants.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = rr_last_q + IDX_W'(k);
      if (!gnt && pend_q[cand]) begin
        gnt     = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef BTN_EVT_RESET_PRIORITY_EN
    if (pend_q[0]) begin
      gnt     = 1'b1;
      gnt_idx = '0;
    end
`endif
    gnt = gnt && push_ok && !flush;
  end

  assign push   = gnt;
  assign gnt_oh = push ? (N_BTN'(1) << gnt_idx) : '0;
  assign drops  = flush ? '0 : (BTN_POSEDGE & pend_q & ~gnt_oh);

  always_comb begin
    pend_nxt = (pend_q & ~gnt_oh) | BTN_POSEDGE;
    ovf_nxt  = (|drops) ? 1'b1 : (CLR_OVF ? 1'b0 : ovf_q);
    cnt_rem  = cnt_q - CNT_W'(pop);
    cnt_nxt  = cnt_rem + CNT_W'(push);
    rd_nxt   = rd_q + PTR_W'(pop);
    wr_nxt   = wr_q + PTR_W'(push);
    // Head is precomputed so EVT_ID comes straight from a flop.
    if (cnt_nxt == '0)
      head_nxt = '0;
    else if (cnt_rem == '0)
      head_nxt = gnt_idx;
    else
      head_nxt = mem[rd_nxt];
    if (flush) begin
      pend_nxt = N_BTN'(1);
      cnt_nxt  = '0;
      rd_nxt   = '0;
      wr_nxt   = '0;
      head_nxt = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pend_q    <= '0;
      rr_last_q <= IDX_W'(N_BTN - 1);
      head_q    <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      head_q <= head_nxt;
      cnt_q  <= cnt_nxt;
      rd_q   <= rd_nxt;
      wr_q   <= wr_nxt;
      ovf_q  <= ovf_nxt;
      if (push)
        rr_last_q <= gnt_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && push)
      mem[wr_q] <= gnt_idx;
  end

  assign EVT_VALID = (cnt_q != '0);
  assign EVT_ID    = head_q;
  assign PENDING   = pend_q;
  assign FIFO_CNT  = cnt_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter.
// obs = {EVT_VALID, EVT_ID, FIFO_CNT, PENDING, OVERFLOW}.
module tb_btn_event_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] BTN_POSEDGE = '0;
  logic       EVT_READY = 1'b0;
  logic       CLR_OVF = 1'b0;
  logic       EVT_VALID;
  logic [1:0] EVT_ID;
  logic [3:0] PENDING;
  logic [2:0] FIFO_CNT;
  logic       OVERFLOW;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_v;
  wire  [10:0] obs = {EVT_VALID, EVT_ID, FIFO_CNT, PENDING, OVERFLOW};

  btn_event_arbiter dut (
    .CLK(CLK), .RESET(RESET), .BTN_POSEDGE(BTN_POSEDGE),
    .EVT_READY(EVT_READY), .CLR_OVF(CLR_OVF),
    .EVT_VALID(EVT_VALID), .EVT_ID(EVT_ID), .PENDING(PENDING),
    .FIFO_CNT(FIFO_CNT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    BTN_POSEDGE = '0;
    EVT_READY = 1'b0;
    CLR_OVF = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    exp_v = {1'b0, 2'd0, 3'd0, 4'b0000, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset got %b exp %b", obs, exp_v);
    end
  endtask

  task automatic test_single();
    do_reset();
    EVT_READY = 1'b1;
    BTN_POSEDGE = 4'b0100;
    tick();
    BTN_POSEDGE = '0;
    exp_v = {1'b0, 2'd0, 3'd0, 4'b0100, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_t1 got %b exp %b", obs, exp_v);
    end
    tick();
    exp_v = {1'b1, 2'd2, 3'd1, 4'b0000, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_t2 got %b exp %b", obs, exp_v);
    end
    tick();
    exp_v = {1'b0, 2'd0, 3'd0, 4'b0000, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_t3 got %b exp %b", obs, exp_v);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    EVT_READY = 1'b1;
    BTN_POSEDGE = 4'b1111;
    tick();
    BTN_POSEDGE = '0;
    checks++;
    if (PENDING !== 4'b1111) begin
      errors++;
      $display("FAIL simul_pend got %b exp 1111", PENDING);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({EVT_VALID, EVT_ID, OVERFLOW} !== {1'b1, 2'(i), 1'b0}) begin
        errors++;
        $display("FAIL simul_evt%0d got v=%b id=%0d ovf=%b exp v=1 id=%0d ovf=0",
                 i, EVT_VALID, EVT_ID, OVERFLOW, i);
      end
    end
    tick();
    exp_v = {1'b0, 2'd0, 3'd0, 4'b0000, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL simul_end got %b exp %b", obs, exp_v);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    EVT_READY = 1'b1;
    BTN_POSEDGE = 4'b0010;
    tick();
    BTN_POSEDGE = '0;
    tick();
    checks++;
    if ({EVT_VALID, EVT_ID, dut.rr_last_q} !== {1'b1, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL fair_first got v=%b id=%0d rr=%0d exp v=1 id=1 rr=1",
               EVT_VALID, EVT_ID, dut.rr_last_q);
    end
    BTN_POSEDGE = 4'b0011;
    tick();
    BTN_POSEDGE = '0;
    checks++;
    if ({EVT_VALID, PENDING} !== {1'b0, 4'b0011}) begin
      errors++;
      $display("FAIL fair_pend got v=%b pend=%b exp v=0 pend=0011",
               EVT_VALID, PENDING);
    end
    tick();
    checks++;
    if ({EVT_VALID, EVT_ID, dut.rr_last_q} !== {1'b1, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL fair_g0 got v=%b id=%0d rr=%0d exp v=1 id=0 rr=0",
               EVT_VALID, EVT_ID, dut.rr_last_q);
    end
    tick();
    checks++;
    if ({EVT_VALID, EVT_ID, dut.rr_last_q} !== {1'b1, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL fair_g1 got v=%b id=%0d rr=%0d exp v=1 id=1 rr=1",
               EVT_VALID, EVT_ID, dut.rr_last_q);
    end
  endtask

  task automatic test_backpressure();
    int got [8];
    int n = 0;
    int expo [5] = '{0, 1, 2, 3, 0};
    do_reset();
    EVT_READY = 1'b0;
    for (int b = 0; b < 5; b++) begin
      BTN_POSEDGE = 4'b0001 << (b % 4);
      tick();
    end
    BTN_POSEDGE = '0;
    tick();
    exp_v = {1'b1, 2'd0, 3'd4, 4'b0001, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bp_full got %b exp %b", obs, exp_v);
    end
    BTN_POSEDGE = 4'b0001;
    tick();
    BTN_POSEDGE = '0;
    exp_v = {1'b1, 2'd0, 3'd4, 4'b0001, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bp_ovf got %b exp %b", obs, exp_v);
    end
    EVT_READY = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (EVT_VALID && n < 8) begin
        got[n] = int'(EVT_ID);
        n++;
      end
      tick();
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL bp_count got %0d exp 5", n);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= n || got[i] !== expo[i]) begin
        errors++;
        $display("FAIL bp_order%0d got %0d exp %0d", i,
                 (i < n) ? got[i] : -1, expo[i]);
      end
    end
    exp_v = {1'b0, 2'd0, 3'd0, 4'b0000, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bp_end got %b exp %b", obs, exp_v);
    end
  endtask

  task automatic test_overflow_clear();
    do_reset();
    EVT_READY = 1'b0;
    BTN_POSEDGE = 4'b0011;
    tick();
    BTN_POSEDGE = 4'b0010;
    tick();
    BTN_POSEDGE = '0;
    exp_v = {1'b1, 2'd0, 3'd1, 4'b0010, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ovf_drop got %b exp %b", obs, exp_v);
    end
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    exp_v = {1'b1, 2'd0, 3'd2, 4'b0000, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ovf_clr got %b exp %b", obs, exp_v);
    end
    BTN_POSEDGE = 4'b0101;
    tick();
    BTN_POSEDGE = 4'b0001;
    CLR_OVF = 1'b1;
    tick();
    BTN_POSEDGE = '0;
    CLR_OVF = 1'b0;
    exp_v = {1'b1, 2'd0, 3'd3, 4'b0001, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ovf_set_wins got %b exp %b", obs, exp_v);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    EVT_READY = 1'b0;
    for (int b = 0; b < 4; b++) begin
      BTN_POSEDGE = 4'b0001 << b;
      tick();
    end
    BTN_POSEDGE = '0;
    exp_v = {1'b1, 2'd0, 3'd3, 4'b1000, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_setup got %b exp %b", obs, exp_v);
    end
    RESET = 1'b0;
    BTN_POSEDGE = 4'b0010;
    tick();
    RESET = 1'b1;
    BTN_POSEDGE = '0;
    exp_v = {1'b0, 2'd0, 3'd0, 4'b0000, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_rst got %b exp %b", obs, exp_v);
    end
    tick();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_after got %b exp %b", obs, exp_v);
    end
  endtask

`ifdef BTN_EVT_RESET_PRIORITY_EN
  task automatic test_flush();
    do_reset();
    EVT_READY = 1'b0;
    BTN_POSEDGE = 4'b0100;
    tick();
    BTN_POSEDGE = 4'b1000;
    tick();
    BTN_POSEDGE = 4'b0010;
    tick();
    BTN_POSEDGE = '0;
    exp_v = {1'b1, 2'd2, 3'd2, 4'b0010, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL flush_setup got %b exp %b", obs, exp_v);
    end
    BTN_POSEDGE = 4'b0001;
    tick();
    BTN_POSEDGE = '0;
    exp_v = {1'b0, 2'd0, 3'd0, 4'b0001, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL flush_empty got %b exp %b", obs, exp_v);
    end
    tick();
    exp_v = {1'b1, 2'd0, 3'd1, 4'b0000, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL flush_evt0 got %b exp %b", obs, exp_v);
    end
  endtask
`endif

  initial begin
    @(negedge CLK);
    test_reset();
    test_single();
    test_mid_reset();
`ifdef BTN_EVT_RESET_PRIORITY_EN
    test_flush();
`else
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_overflow_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
